// File: rtl/conv_pkg.sv
// Shared definitions for the multi-channel convolution engine: FSM encoding
// and elaboration-time geometry helpers.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } conv_state_t;

    function automatic int out_size(input int n, input int k, input int p, input int s);
        return ((n - k + 2 * p) / s) + 1;
    endfunction

    // Width needed to index `depth` entries; never below one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate stage; the next accumulator value is exported so
// the final tap can be captured in the same edge that folds it in.
module mac_unit
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic                     i_pad,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc_next
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W-1:0]    acc;

    always_comb begin
        prod       = i_a * i_b;
        prod_ext   = i_pad ? '0 : ACC_W'(prod);
        acc_base   = i_clr ? '0 : acc;
        o_acc_next = i_en ? (acc_base + prod_ext) : acc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc <= '0;
        end else begin
            acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/conv_mc_engine.sv
// Multi-channel 2D convolution engine: walks output pixels in raster order,
// streams one BRAM read pair per cycle into the MAC and emits each result.
//
//   state | meaning
//   IDLE  | waiting for i_go
//   RUN   | issuing one fm/weight read pair per cycle (c, kr, kc)
//   DRAIN | last read returning; result captured on exit
//   OUT   | o_valid held until i_ready
//   DONE  | one-cycle o_done pulse
module conv_mc_engine
    import conv_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 48,
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 8,
    parameter int PADDING     = 1,
    parameter int STRIDE      = 1,
    parameter int IN_CH       = 2,
    parameter int RELU        = 0
)
(
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_go,
    output logic [addr_w(IN_CH*FM_SIZE*FM_SIZE)-1:0]       o_fm_addr,
    input  logic signed [DATA_W-1:0]                       i_fm_data,
    output logic [addr_w(IN_CH*KERNEL_SIZE*KERNEL_SIZE)-1:0] o_w_addr,
    input  logic signed [DATA_W-1:0]                       i_w_data,
    output logic signed [ACC_W-1:0]                        o_result,
    output logic                                           o_valid,
    input  logic                                           i_ready,
    output logic                                           o_busy,
    output logic                                           o_done
);

    localparam int OUT_SIZE = out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE);
    localparam int FM_AW    = addr_w(IN_CH * FM_SIZE * FM_SIZE);
    localparam int W_AW     = addr_w(IN_CH * KERNEL_SIZE * KERNEL_SIZE);
    localparam int CH_W     = addr_w(IN_CH);
    localparam int K_W      = addr_w(KERNEL_SIZE);
    localparam int O_W      = addr_w(OUT_SIZE);

    conv_state_t state, next_state;

    logic [CH_W-1:0] ch;
    logic [K_W-1:0]  kr, kc;
    logic [O_W-1:0]  ox, oy;

    logic last_tap, first_tap, last_pix, xfer;
    logic tap_pad;
    int   row, col, fm_lin, w_lin;

    logic tap_vld_d, tap_first_d, tap_pad_d;
    logic signed [ACC_W-1:0] acc_next;

    assign last_tap  = (ch == CH_W'(IN_CH - 1)) && (kr == K_W'(KERNEL_SIZE - 1)) &&
                       (kc == K_W'(KERNEL_SIZE - 1));
    assign first_tap = (ch == '0) && (kr == '0) && (kc == '0);
    assign last_pix  = (ox == O_W'(OUT_SIZE - 1)) && (oy == O_W'(OUT_SIZE - 1));
    assign xfer      = (state == OUT) && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (i_go) next_state = RUN;
            RUN:     if (last_tap) next_state = DRAIN;
            DRAIN:   next_state = OUT;
            OUT:     if (i_ready) next_state = last_pix ? DONE : RUN;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Window origin is (oy*S - P, ox*S - P); taps landing in the pad ring
    // read address 0 and are zeroed in the MAC.
    always_comb begin
        row     = int'(oy) * STRIDE - PADDING + int'(kr);
        col     = int'(ox) * STRIDE - PADDING + int'(kc);
        tap_pad = (row < 0) || (row >= FM_SIZE) || (col < 0) || (col >= FM_SIZE);
        fm_lin  = int'(ch) * FM_SIZE * FM_SIZE + row * FM_SIZE + col;
        w_lin   = int'(ch) * KERNEL_SIZE * KERNEL_SIZE + int'(kr) * KERNEL_SIZE + int'(kc);
    end

    always_comb begin
        o_fm_addr = '0;
        o_w_addr  = '0;
        if (state == RUN) begin
            o_fm_addr = tap_pad ? '0 : FM_AW'(fm_lin);
            o_w_addr  = W_AW'(w_lin);
        end
        o_valid = (state == OUT);
        o_busy  = (state != IDLE);
        o_done  = (state == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || state == IDLE) begin
            ch <= '0;
            kr <= '0;
            kc <= '0;
            ox <= '0;
            oy <= '0;
        end else begin
            if (state == RUN) begin
                if (kc == K_W'(KERNEL_SIZE - 1)) begin
                    kc <= '0;
                    if (kr == K_W'(KERNEL_SIZE - 1)) begin
                        kr <= '0;
                        ch <= (ch == CH_W'(IN_CH - 1)) ? '0 : ch + CH_W'(1);
                    end else begin
                        kr <= kr + K_W'(1);
                    end
                end else begin
                    kc <= kc + K_W'(1);
                end
            end
            if (xfer) begin
                if (ox == O_W'(OUT_SIZE - 1)) begin
                    ox <= '0;
                    oy <= (oy == O_W'(OUT_SIZE - 1)) ? '0 : oy + O_W'(1);
                end else begin
                    ox <= ox + O_W'(1);
                end
            end
        end
    end

    // Tap qualifiers travel alongside the 1-cycle BRAM read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tap_vld_d   <= 1'b0;
            tap_first_d <= 1'b0;
            tap_pad_d   <= 1'b0;
        end else begin
            tap_vld_d   <= (state == RUN);
            tap_first_d <= (state == RUN) && first_tap;
            tap_pad_d   <= tap_pad;
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (tap_vld_d),
        .i_clr      (tap_first_d),
        .i_pad      (tap_pad_d),
        .i_a        (i_fm_data),
        .i_b        (i_w_data),
        .o_acc_next (acc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_result <= '0;
        end else if (state == DRAIN) begin
            o_result <= (RELU != 0 && acc_next[ACC_W-1]) ? '0 : acc_next;
        end
    end

endmodule

// File: tb/tb_conv_mc_engine.sv
// Scoreboard bench: two engine configurations fed random BRAM contents and
// compared against a direct arithmetic convolution model.
module tb_conv_mc_engine;

    // Instance A: channels, padding and stride 2. Instance B: ReLU, no padding.
    localparam int CA = 2, KA = 3, NA = 5, PA = 1, SA = 2, RA = 0;
    localparam int CB = 2, KB = 2, NB = 4, PB = 0, SB = 1, RB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, go_a, go_b, rdy_a, rdy_b;
    logic [5:0] fa_addr;
    logic [4:0] wa_addr;
    logic [4:0] fb_addr;
    logic [2:0] wb_addr;
    logic signed [15:0] fa_data, wa_data, fb_data, wb_data;
    logic signed [47:0] res_a, res_b;
    logic va, vb, busy_a, busy_b, done_a, done_b;

    logic signed [15:0] fm_mem [2][64];
    logic signed [15:0] w_mem  [2][32];

    always @(posedge clk) begin
        fa_data <= fm_mem[0][fa_addr];
        wa_data <= w_mem[0][wa_addr];
        fb_data <= fm_mem[1][fb_addr];
        wb_data <= w_mem[1][wb_addr];
    end

    conv_mc_engine #(.DATA_W(16), .ACC_W(48), .KERNEL_SIZE(KA), .FM_SIZE(NA),
                     .PADDING(PA), .STRIDE(SA), .IN_CH(CA), .RELU(RA)) u_a (
        .i_clk(clk), .i_rst(rst), .i_go(go_a),
        .o_fm_addr(fa_addr), .i_fm_data(fa_data),
        .o_w_addr(wa_addr), .i_w_data(wa_data),
        .o_result(res_a), .o_valid(va), .i_ready(rdy_a),
        .o_busy(busy_a), .o_done(done_a));

    conv_mc_engine #(.DATA_W(16), .ACC_W(48), .KERNEL_SIZE(KB), .FM_SIZE(NB),
                     .PADDING(PB), .STRIDE(SB), .IN_CH(CB), .RELU(RB)) u_b (
        .i_clk(clk), .i_rst(rst), .i_go(go_b),
        .o_fm_addr(fb_addr), .i_fm_data(fb_data),
        .o_w_addr(wb_addr), .i_w_data(wb_data),
        .o_result(res_b), .o_valid(vb), .i_ready(rdy_b),
        .o_busy(busy_b), .o_done(done_b));

    typedef struct {
        int     id;
        longint val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit     hold_v   [2];
    longint hold_res [2];
    int     hold_addr[2];
    bit     done_exp [2];
    int     busy_cnt [2];
    int     xfers    [2];
    int     bp_mode = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic get_v(input int id);
        return (id == 0) ? va : vb;
    endfunction

    function automatic logic get_busy(input int id);
        return (id == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_done(input int id);
        return (id == 0) ? done_a : done_b;
    endfunction

    function automatic longint get_res(input int id);
        return (id == 0) ? longint'(res_a) : longint'(res_b);
    endfunction

    task automatic set_go(input int id, input logic val);
        if (id == 0) go_a = val;
        else         go_b = val;
    endtask

    // Per-instance monitor: done pulse, stall stability and scoreboard pop.
    task automatic mon(input int id, input logic v, input logic signed [47:0] res,
                       input logic rdy, input logic done, input logic busy, input int addr);
        exp_t e;
        if (busy) busy_cnt[id]++;
        if (done_exp[id] || done)
            chk($sformatf("done_pulse_%0d", id), longint'(done), longint'(done_exp[id]));
        done_exp[id] = 1'b0;
        if (hold_v[id]) begin
            chk($sformatf("stall_valid_%0d", id), longint'(v), 1);
            chk($sformatf("stall_result_%0d", id), longint'(res), hold_res[id]);
            chk($sformatf("stall_addr_%0d", id), longint'(addr), longint'(hold_addr[id]));
        end
        hold_v[id]    = v && !rdy && !rst;
        hold_res[id]  = longint'(res);
        hold_addr[id] = addr;
        if (v && rdy && !rst) begin
            xfers[id]++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_output_%0d: got %0d, required no output", id, longint'(res));
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("result_inst_%0d", id), longint'(id), longint'(e.id));
                chk($sformatf("result_%0d", id), longint'(res), e.val);
                if (exp_q.size() == 0) done_exp[id] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, va, res_a, rdy_a, done_a, busy_a, int'(fa_addr));
        mon(1, vb, res_b, rdy_b, done_b, busy_b, int'(fb_addr));
    end

    always @(posedge clk) begin
        #1;
        rdy_a = (bp_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        rdy_b = (bp_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // One full pass: random BRAM contents, model results queued, then the
    // engine is started and watched until it returns to idle.
    task automatic run(input int id, input int mode, input int abort_at);
        int C, K, N, P, S, R, O, taps, n, b0, x0, r, c;
        longint acc;
        bit aborted;
        exp_t e;
        aborted = 1'b0;
        C = (id == 0) ? CA : CB;  K = (id == 0) ? KA : KB;
        N = (id == 0) ? NA : NB;  P = (id == 0) ? PA : PB;
        S = (id == 0) ? SA : SB;  R = (id == 0) ? RA : RB;
        O = ((N - K + 2 * P) / S) + 1;
        taps = C * K * K;
        for (int i = 0; i < C * N * N; i++) fm_mem[id][i] = 16'($urandom);
        for (int i = 0; i < taps; i++)      w_mem[id][i]  = 16'($urandom);
        for (int oy = 0; oy < O; oy++) begin
            for (int ox = 0; ox < O; ox++) begin
                acc = 0;
                for (int ci = 0; ci < C; ci++)
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++) begin
                            r = oy * S - P + kr;
                            c = ox * S - P + kc;
                            if (r >= 0 && r < N && c >= 0 && c < N)
                                acc += longint'(fm_mem[id][ci*N*N + r*N + c]) *
                                       longint'(w_mem[id][ci*K*K + kr*K + kc]);
                        end
                if (R != 0 && acc < 0) acc = 0;
                e.id = id;
                e.val = acc;
                exp_q.push_back(e);
            end
        end
        bp_mode = mode;
        b0 = busy_cnt[id];
        x0 = xfers[id];
        @(posedge clk); #1;
        set_go(id, 1'b1);
        @(posedge clk); #1;
        set_go(id, 1'b0);
        n = 1;
        chk("busy_after_go", longint'(get_busy(id)), 1);
        while (!get_v(id) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("first_valid_latency", n, taps + 2);
        n = 0;
        while (get_busy(id) && n < 5000) begin
            if (n == 5) set_go(id, 1'b1);
            if (n == 6) set_go(id, 1'b0);
            if (abort_at > 0 && (xfers[id] - x0) >= abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_valid", longint'(get_v(id)), 0);
                chk("abort_busy", longint'(get_busy(id)), 0);
                chk("abort_done", longint'(get_done(id)), 0);
                chk("abort_result", get_res(id), 0);
                rst = 1'b0;
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        set_go(id, 1'b0);
        chk("run_in_time", longint'(n < 5000), 1);
        if (!aborted) begin
            chk("queue_drained", longint'(exp_q.size()), 0);
            if (mode == 0)
                chk("busy_cycles", longint'(busy_cnt[id] - b0), longint'(O * O * (taps + 2) + 1));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        go_a = 1'b0;
        go_b = 1'b0;
        for (int i = 0; i < 64; i++) begin
            fm_mem[0][i] = '0;
            fm_mem[1][i] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            w_mem[0][i] = '0;
            w_mem[1][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_a", longint'(va), 0);
        chk("reset_valid_b", longint'(vb), 0);
        chk("reset_busy_a", longint'(busy_a), 0);
        chk("reset_done_b", longint'(done_b), 0);
        chk("reset_result_a", longint'(res_a), 0);
        chk("reset_result_b", longint'(res_b), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(0, 0, 0);
        run(0, 1, 0);
        run(0, 0, 4);
        run(0, 0, 0);
        run(1, 0, 0);
        run(1, 1, 0);
        run(1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
